// File: rtl/result_sender.sv
// Streams the N x N result matrix from the result RAM to the UART transmitter.
// Elements are read in row-major order and sent most significant byte first.
module result_sender #(
    parameter int DATA_W = 16,
    parameter int MAX_N  = 8,
    parameter int ADDR_W = 6
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [3:0]        i_matrix_size,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [DATA_W-1:0] i_rd_data,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_start,
    input  logic              i_tx_busy,
    output logic              o_busy,
    output logic              o_done
);

    localparam int BYTES  = DATA_W / 8;
    localparam int IDX_W  = $clog2(MAX_N * MAX_N + 1);
    localparam int BCNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [3:0]        MAX_N_L   = 4'(MAX_N);
    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_SEND  = 3'd3,
        S_HOLD  = 3'd4,
        S_WAIT  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [IDX_W-1:0]    r_index;
    logic [IDX_W-1:0]    r_lastIdx;
    logic [BCNT_W-1:0]   r_byteCnt;
    logic [DATA_W-1:0]   r_shift;
    logic                r_done;

    logic [3:0]          w_effN;
    logic [IDX_W-1:0]    w_total;
    logic                w_moreBytes;
    logic                w_moreElems;

    // Oversized requests are clamped so the index never leaves the RAM.
    assign w_effN      = (i_matrix_size > MAX_N_L) ? MAX_N_L : i_matrix_size;
    assign w_total     = IDX_W'(w_effN) * IDX_W'(w_effN);
    assign w_moreBytes = (r_byteCnt != LAST_BYTE);
    assign w_moreElems = (r_index < r_lastIdx);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next = (w_effN == 4'd0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: w_next = S_LOAD;
            S_LOAD:  w_next = S_SEND;
            S_SEND: begin
                if (!i_tx_busy) begin
                    w_next = S_HOLD;
                end
            end
            // The transmitter may not have raised busy yet, so this cycle ignores it.
            S_HOLD:  w_next = S_WAIT;
            S_WAIT: begin
                if (!i_tx_busy) begin
                    if (w_moreBytes) begin
                        w_next = S_SEND;
                    end else if (w_moreElems) begin
                        w_next = S_FETCH;
                    end else begin
                        w_next = S_DONE;
                    end
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_index   <= '0;
            r_lastIdx <= '0;
            r_byteCnt <= '0;
            r_shift   <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= (r_state == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_index   <= '0;
                        r_byteCnt <= '0;
                        r_lastIdx <= w_total - IDX_W'(1);
                    end
                end
                S_LOAD: begin
                    r_shift   <= i_rd_data;
                    r_byteCnt <= '0;
                end
                S_WAIT: begin
                    if (w_next == S_SEND) begin
                        r_shift   <= r_shift << 8;
                        r_byteCnt <= r_byteCnt + BCNT_W'(1);
                    end else if (w_next == S_FETCH) begin
                        r_index <= r_index + IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        o_rd_en    = (r_state == S_FETCH);
        o_rd_addr  = ADDR_W'(r_index);
        o_tx_data  = r_shift[DATA_W-1 -: 8];
        o_tx_start = (r_state == S_SEND) && !i_tx_busy;
        o_busy     = (r_state != S_IDLE);
        o_done     = r_done;
    end

endmodule

// File: tb/tb_result_sender.sv
// Scoreboard bench for result_sender: stimulus pushes expected RAM addresses and
// tx bytes, a monitor pops and compares them whenever the DUT strobes rd_en/tx_start.
module tb_result_sender;

    localparam int DATA_W = 16;
    localparam int MAX_N  = 8;
    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [3:0]        matrixSize = 4'd0;
    logic              rdEn;
    logic [ADDR_W-1:0] rdAddr;
    logic [DATA_W-1:0] rdData = '0;
    logic [7:0]        txData;
    logic              txStart;
    logic              txBusy;
    logic              busy;
    logic              done;

    logic [DATA_W-1:0] ram [64];
    logic [7:0]        expByteQ [$];
    logic [ADDR_W-1:0] expAddrQ [$];

    int checks = 0;
    int errors = 0;
    int txStartCount = 0;
    int rdCount = 0;
    int doneCount = 0;
    logic [ADDR_W-1:0] lastAddr = '0;

    int   busyLen = 0;
    int   busyCnt = 0;
    logic forceBusy = 1'b0;

    result_sender #(.DATA_W(DATA_W), .MAX_N(MAX_N), .ADDR_W(ADDR_W)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .i_matrix_size (matrixSize),
        .o_rd_en       (rdEn),
        .o_rd_addr     (rdAddr),
        .i_rd_data     (rdData),
        .o_tx_data     (txData),
        .o_tx_start    (txStart),
        .i_tx_busy     (txBusy),
        .o_busy        (busy),
        .o_done        (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rdEn) rdData <= ram[rdAddr];
    end

    // UART model: busy for busyLen cycles after each tx_start, or forced high.
    assign txBusy = forceBusy || (busyCnt > 0);
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) busyCnt <= 0;
        else if (txStart) busyCnt <= busyLen;
        else if (busyCnt > 0) busyCnt <= busyCnt - 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] size);
        @(posedge clk);
        #1 matrixSize = size;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        matrixSize = 4'd5;
    endtask

    task automatic pushElement(input int addr);
        expAddrQ.push_back(ADDR_W'(addr));
        expByteQ.push_back(ram[addr][15:8]);
        expByteQ.push_back(ram[addr][7:0]);
    endtask

    task automatic waitDone(input int maxCycles, input string name);
        int n = 0;
        while (n < maxCycles) begin
            @(negedge clk);
            if (done === 1'b1) break;
            n++;
        end
        checkOutput(name, 32'(done), 1);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " rd_en"}, 32'(rdEn), 0);
        checkOutput({tag, " rd_addr"}, 32'(rdAddr), 0);
        checkOutput({tag, " tx_data"}, 32'(txData), 0);
        checkOutput({tag, " tx_start"}, 32'(txStart), 0);
        checkOutput({tag, " busy"}, 32'(busy), 0);
        checkOutput({tag, " done"}, 32'(done), 0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (txStart) begin
                    txStartCount++;
                    if (expByteQ.size() == 0) checkOutput("tx_start with empty queue", 32'(txStart), 0);
                    else checkOutput("tx_data", 32'(txData), 32'(expByteQ.pop_front()));
                end
                if (rdEn) begin
                    rdCount++;
                    lastAddr = rdAddr;
                    if (expAddrQ.size() == 0) checkOutput("rd_en with empty queue", 32'(rdEn), 0);
                    else checkOutput("rd_addr", 32'(rdAddr), 32'(expAddrQ.pop_front()));
                end
                if (done) doneCount++;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int baseTx, baseRd, baseDone, n;
        for (int a = 0; a < 64; a++) ram[a] = {8'(a), 8'(a) ^ 8'hA5};
        ram[0] = 16'h0102;
        ram[1] = 16'h0304;
        ram[2] = 16'h0506;
        ram[3] = 16'h0708;

        repeat (3) @(posedge clk);
        #2 checkAllZero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // N=2 with a slow transmitter; bytes are hand-listed.
        busyLen = 10;
        for (int a = 0; a < 4; a++) expAddrQ.push_back(ADDR_W'(a));
        foreach (ram[i]) begin end
        expByteQ.push_back(8'h01); expByteQ.push_back(8'h02);
        expByteQ.push_back(8'h03); expByteQ.push_back(8'h04);
        expByteQ.push_back(8'h05); expByteQ.push_back(8'h06);
        expByteQ.push_back(8'h07); expByteQ.push_back(8'h08);
        baseTx = txStartCount; baseRd = rdCount; baseDone = doneCount;
        applyStimulus(4'd2);
        @(negedge clk);
        checkOutput("c1 rd_en", 32'(rdEn), 1);
        checkOutput("c1 busy", 32'(busy), 1);
        @(negedge clk);
        checkOutput("c2 rd_en", 32'(rdEn), 0);
        @(negedge clk);
        checkOutput("c3 tx_start", 32'(txStart), 1);
        waitDone(2000, "n2 done");
        checkOutput("n2 busy at done", 32'(busy), 0);
        @(posedge clk);
        checkOutput("n2 tx_start count", txStartCount - baseTx, 8);
        checkOutput("n2 read count", rdCount - baseRd, 4);
        checkOutput("n2 done count", doneCount - baseDone, 1);

        // Zero-size matrix goes straight to done.
        baseTx = txStartCount; baseRd = rdCount;
        applyStimulus(4'd0);
        @(negedge clk);
        checkOutput("n0 c1 busy", 32'(busy), 1);
        checkOutput("n0 c1 done", 32'(done), 0);
        checkOutput("n0 c1 rd_en", 32'(rdEn), 0);
        @(negedge clk);
        checkOutput("n0 c2 done", 32'(done), 1);
        checkOutput("n0 c2 busy", 32'(busy), 0);
        @(negedge clk);
        checkOutput("n0 c3 done", 32'(done), 0);
        checkOutput("n0 tx_start count", txStartCount - baseTx, 0);
        checkOutput("n0 read count", rdCount - baseRd, 0);

        // Oversized request is clamped to MAX_N.
        busyLen = 2;
        for (int a = 0; a < 64; a++) pushElement(a);
        baseTx = txStartCount; baseRd = rdCount; baseDone = doneCount;
        applyStimulus(4'd12);
        waitDone(5000, "n12 done");
        @(posedge clk);
        checkOutput("n12 read count", rdCount - baseRd, 64);
        checkOutput("n12 last rd_addr", 32'(lastAddr), 63);
        checkOutput("n12 tx_start count", txStartCount - baseTx, 128);
        checkOutput("n12 done count", doneCount - baseDone, 1);

        // Transmitter stuck busy while in SEND, with a stray start mid-stall.
        busyLen = 3;
        forceBusy = 1'b1;
        for (int a = 0; a < 4; a++) pushElement(a);
        baseTx = txStartCount; baseRd = rdCount;
        applyStimulus(4'd2);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 100; i++) begin
            checkOutput("stall tx_start", 32'(txStart), 0);
            checkOutput("stall tx_data", 32'(txData), 32'h01);
            if (i == 50) begin matrixSize = 4'd3; start = 1'b1; end
            if (i == 51) start = 1'b0;
            @(negedge clk);
        end
        @(posedge clk);
        #1 forceBusy = 1'b0;
        @(negedge clk);
        checkOutput("release tx_start", 32'(txStart), 1);
        @(negedge clk);
        checkOutput("release hold tx_start", 32'(txStart), 0);
        waitDone(2000, "stall done");
        @(posedge clk);
        checkOutput("stall tx_start count", txStartCount - baseTx, 8);
        checkOutput("stall read count", rdCount - baseRd, 4);

        // Reset in the middle of an N=2 transfer.
        busyLen = 4;
        for (int a = 0; a < 4; a++) pushElement(a);
        baseTx = txStartCount;
        applyStimulus(4'd2);
        n = 0;
        while (txStartCount < baseTx + 3 && n < 500) begin
            @(posedge clk);
            n++;
        end
        checkOutput("third tx_start reached", txStartCount - baseTx, 3);
        #3 rst_n = 1'b0;
        #1 checkAllZero("async reset");
        expByteQ.delete();
        expAddrQ.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        baseTx = txStartCount; baseRd = rdCount;
        repeat (20) @(negedge clk);
        checkOutput("post-reset tx_start count", txStartCount - baseTx, 0);
        checkOutput("post-reset read count", rdCount - baseRd, 0);
        pushElement(0);
        applyStimulus(4'd1);
        waitDone(500, "after reset done");
        @(posedge clk);
        checkOutput("after reset tx_start count", txStartCount - baseTx, 2);

        // Back-to-back transfers: new start in the cycle right after done.
        busyLen = 0;
        pushElement(0);
        pushElement(0);
        baseDone = doneCount;
        applyStimulus(4'd1);
        waitDone(500, "b2b first done");
        @(posedge clk);
        #1 matrixSize = 4'd1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        checkOutput("b2b rd_en", 32'(rdEn), 1);
        waitDone(500, "b2b second done");
        @(posedge clk);
        checkOutput("b2b done count", doneCount - baseDone, 2);

        checkOutput("byte queue drained", expByteQ.size(), 0);
        checkOutput("addr queue drained", expAddrQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/result_sender.md
# result_sender

Downstream stage of the matrix control FSM. When the control unit enters its send-result phase, this block reads the N×N result matrix from the result RAM in row-major order. It splits each element into bytes, most significant byte first, and feeds them one at a time to the UART transmitter through the tx_start/tx_busy handshake. It reports completion with a single-cycle done pulse.

## Interface
- DATA_W, 16: result element width in bits; must be a multiple of 8. BYTES = DATA_W/8.
- MAX_N, 8: largest supported matrix dimension.
- ADDR_W, 6: result RAM address width; must satisfy 2^ADDR_W ≥ MAX_N².
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- start  in  1  pulse from control unit; begins a transfer; sampled only when busy=0.
- matrix_size  in  4  N; sampled on the accepted start cycle.
- rd_en  out  1  result RAM read strobe.
- rd_addr  out  ADDR_W  result RAM address = row*N + col.
- rd_data  in  DATA_W  RAM read data; valid the cycle after rd_en.
- tx_data  out  8  byte presented to the UART transmitter.
- tx_start  out  1  one-cycle request to transmit tx_data.
- tx_busy  in  1  transmitter busy.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last byte completes.

## Operation
- Effective size Ne: if matrix_size > MAX_N, Ne = MAX_N. Otherwise Ne = matrix_size. Total elements T = Ne*Ne; element index counter is wide enough to hold MAX_N².
- States:
  - IDLE: accept start. If Ne=0, go to DONE. Otherwise clear the index and byte counters and go to FETCH.
  - FETCH: rd_en=1 and rd_addr=index for one cycle; go to LOAD.
  - LOAD: capture rd_data into a shift register; byte counter=0; go to SEND.
  - SEND: hold tx_data = current top byte. When tx_busy=0, pulse tx_start and go to HOLD. While tx_busy=1, stay and keep tx_start low.
  - HOLD: one cycle; tx_busy is ignored; go to WAIT.
  - WAIT: stay while tx_busy=1. On tx_busy=0:
    - if bytes remain, shift left 8 and go to SEND;
    - else if index < T-1, increment index and go to FETCH;
    - else go to DONE.
  - DONE: done=1 for one cycle; go to IDLE.
- start is ignored in every state except IDLE. matrix_size changes after acceptance have no effect.
- tx_data is stable from entry into SEND until leaving WAIT.
- Illegal state encodings return to IDLE.

## Timing
- Reset (rst=0, asynchronous) forces:
  - state IDLE;
  - rd_en=0, rd_addr=0, tx_data=0, tx_start=0, busy=0, done=0;
  - counters and shift register cleared.
- Reset mid-transfer aborts immediately. No tx_start pulse is emitted after reset release until a new start.
- With start accepted at cycle 0 and tx_busy=0:
  - rd_en at cycle 1;
  - data captured at cycle 2;
  - first tx_start at cycle 3.
- busy rises at cycle 1 and falls when done is high.
- Per byte: minimum 3 cycles (SEND, HOLD, WAIT) plus the transmitter busy time.
- Per element: 2 additional cycles (FETCH, LOAD).
- Ne=0: done pulses at cycle 2 (IDLE→DONE at cycle 1). No rd_en and no tx_start are issued.
- A start in the cycle after done (back in IDLE) is accepted normally.
- Exactly one tx_start per byte. Total tx_start pulses per transfer = T*BYTES.

## Test plan
- N=2, RAM = 0x0102,0x0304,0x0506,0x0708, transmitter model busy 10 cycles per byte:
  - tx bytes 01 02 03 04 05 06 07 08 in order;
  - rd_addr sequence 0,1,2,3;
  - exactly 8 tx_start pulses and one done pulse.
- matrix_size=0 → done at cycle 2 after start; rd_en and tx_start never assert; busy high for cycle 1 only.
- matrix_size=12, MAX_N=8 → 64 reads, last rd_addr=63, 128 tx_start pulses, one done.
- tx_busy held high for 100 cycles while in SEND:
  - tx_start stays low and tx_data stable throughout;
  - on release, exactly one tx_start;
  - a start pulsed mid-transfer has no effect on the address sequence.
- rst driven low after the 3rd tx_start of an N=2 transfer:
  - all outputs 0 asynchronously;
  - after release, no tx_start until a new start;
  - a new start with N=1 sends the bytes of address 0 only.
- Back-to-back: second start (N=1) in the cycle after the first done → accepted; rd_en asserts the following cycle.
